grant_sequencer: RTL
====================

Name: grant_sequencer

Overview:
- Sequences one output port's priority-aware round-robin arbiter (select_grant instance, parameters N/P) across a packet transfer.
- Presents VOQ requests to the arbiter and latches the resulting grant and priority.
- Drives the arbiter's busy and round-robin-update inputs so the pointer advances exactly once per granted packet.
- Holds the granted input for the packet length, then releases the port.

Parameters:
- N, 25, number of input ports (width of grant vector)
- P, 8, number of priority levels
- LEN_W, 8, width of per-input packet length field (flits)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_port_req  in  P*N  VOQ requests; bit i*N+j = input j at priority index i (index P-1 highest)
- i_pkt_len  in  N*LEN_W  head-packet length of input j at bits [j*LEN_W +: LEN_W]
- i_accept  in  1  downstream can take a flit this cycle
- i_rr_enable  in  1  config: 1 = advance round-robin pointer on each grant
- o_arb_req  out  P*N  request vector to arbiter i_port_req
- i_arb_grant  in  N  arbiter o_port_grant (combinational from o_arb_req)
- i_arb_priority  in  P  arbiter o_grant_priority
- o_busy  out  1  to arbiter i_busy
- o_random_robin  out  1  to arbiter i_random_robin
- o_grant  out  N  one-hot granted input, held for the whole transfer
- o_grant_priority  out  P  one-hot priority of the current transfer
- o_valid  out  1  flit transferred this cycle
- o_done  out  1  one-cycle pulse with the last flit
- o_flit_cnt  out  LEN_W  remaining flits including the current one

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State = IDLE.
  - All registered outputs = 0: o_grant, o_grant_priority, o_busy, o_random_robin, o_flit_cnt, o_done; snapshot register = 0.
  - o_valid = 0 and o_arb_req = 0 while reset is high.
- States: IDLE, ARB, LOCK, XFER, REL.
- IDLE:
  - o_arb_req = i_port_req.
  - If |i_port_req -> ARB; else stay.
- ARB:
  - o_arb_req = i_port_req.
  - At the clock edge, if |i_arb_grant:
    - Latch o_grant = i_arb_grant; if multiple bits are set, keep the lowest index only.
    - Latch o_grant_priority = i_arb_priority.
    - Latch snapshot = i_port_req.
    - Latch o_flit_cnt = i_pkt_len of the granted input; length 0 is treated as 1.
    - Set o_busy = 1 and o_random_robin = i_rr_enable. Next state LOCK.
  - If i_arb_grant == 0 (requests withdrawn): go to IDLE, no latching.
- LOCK (exactly 1 cycle):
  - o_arb_req = snapshot, so the arbiter's gnt_priority matches the latched priority.
  - o_busy = 1; o_random_robin = i_rr_enable (registered). The arbiter pointer updates at the end of this cycle.
  - Next state XFER; o_random_robin returns to 0.
- XFER:
  - o_arb_req = 0; o_busy = 1.
  - o_valid = i_accept (combinational).
  - On each accepted cycle o_flit_cnt decrements.
  - When o_flit_cnt == 1 and i_accept: o_done = 1 in the same cycle, next state REL.
  - If i_accept is low, o_flit_cnt holds and o_done = 0.
- REL (1 cycle):
  - o_grant, o_grant_priority, o_flit_cnt = 0; o_busy = 0; o_arb_req = 0.
  - Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> ARB at cycle 1 -> LOCK at cycle 2 -> first possible o_valid at cycle 3.
  - Port reusable 2 cycles after the o_done cycle (REL, then IDLE).
- Request changes after ARB do not affect the transfer in progress; i_pkt_len is sampled only in ARB.
- o_done is never asserted outside XFER. o_grant is one-hot or zero at all times.

Test Plan:
- Single request (input 3, priority P-1, len 4, i_accept = 1) -> o_grant = 0x8 from cycle 2, o_valid cycles 3-6, o_done at cycle 6, o_busy low at cycle 7, arbiter pointer advanced once.
- Requests at inputs 2 and 5, same priority, len 1 each, back-to-back with i_rr_enable = 1 -> grants alternate 2, 5, 2; with i_rr_enable = 0 -> input 2 granted repeatedly.
- Mixed priorities (input 7 at priority index 1, input 0 at index 6) -> input 0 granted first, o_grant_priority matches index 6 bit.
- i_accept toggling 1,0,0,1,1 with len 3 -> o_flit_cnt sequence 3,2,2,2,1; o_done only on the third accepted cycle.
- i_pkt_len = 0 -> treated as one flit, o_done with first accept; requests dropped in ARB -> return to IDLE with no grant and no o_random_robin pulse.
- Reset asserted mid-XFER (cnt = 2) -> all outputs 0 immediately (asynchronous); after release, a fresh request is arbitrated normally with no leftover o_done.

Source files
------------

// File: rtl/grant_sequencer.sv
// grant_sequencer: drives one output port's round-robin arbiter through a
// packet transfer. Requests go to the arbiter, and the winning grant, its
// priority and the packet length are latched. The arbiter pointer is advanced
// exactly once per packet. The granted input is held until its last flit is
// accepted, and then the port is released.
module grant_sequencer #(
    parameter int N     = 25,
    parameter int P     = 8,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [P*N-1:0]     i_port_req,
    input  logic [N*LEN_W-1:0] i_pkt_len,
    input  logic               i_accept,
    input  logic               i_rr_enable,
    output logic [P*N-1:0]     o_arb_req,
    input  logic [N-1:0]       i_arb_grant,
    input  logic [P-1:0]       i_arb_priority,
    output logic               o_busy,
    output logic               o_random_robin,
    output logic [N-1:0]       o_grant,
    output logic [P-1:0]       o_grant_priority,
    output logic               o_valid,
    output logic               o_done,
    output logic [LEN_W-1:0]   o_flit_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_LOCK = 3'd2;
    localparam logic [2:0] S_XFER = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    localparam logic [LEN_W-1:0] ONE_FLIT = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [P*N-1:0]   snapshot;
    logic [N-1:0]     grant_lsb;
    logic [LEN_W-1:0] sel_len;
    logic [LEN_W-1:0] start_len;
    logic             grant_found;
    logic             any_req;
    logic             any_grant;
    logic             last_flit;

    assign any_req   = |i_port_req;
    assign any_grant = |i_arb_grant;

    // Keep only the lowest-index grant bit and pick that input's head-packet length
    always_comb begin
        grant_lsb   = '0;
        sel_len     = '0;
        grant_found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (i_arb_grant[j] && !grant_found) begin
                grant_found  = 1'b1;
                grant_lsb[j] = 1'b1;
                sel_len      = i_pkt_len[j*LEN_W +: LEN_W];
            end
        end
    end

    // A zero-length head packet still occupies one flit slot
    assign start_len = (sel_len == '0) ? ONE_FLIT : sel_len;

    assign last_flit = (state == S_XFER) && i_accept && (o_flit_cnt == ONE_FLIT);

    // Transfer strobes are only ever combinational from XFER
    assign o_valid = (state == S_XFER) && i_accept;
    assign o_done  = last_flit;

    // Arbiter sees live requests while idle/arbitrating, the frozen snapshot during LOCK
    always_comb begin
        o_arb_req = '0;
        if (!reset) begin
            case (state)
                S_IDLE, S_ARB: o_arb_req = i_port_req;
                S_LOCK:        o_arb_req = snapshot;
                default:       o_arb_req = '0;
            endcase
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ARB;
            S_ARB:   state_nxt = any_grant ? S_LOCK : S_IDLE;
            S_LOCK:  state_nxt = S_XFER;
            S_XFER:  if (last_flit) state_nxt = S_REL;
            S_REL:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant/priority/length latching, pointer-update pulse and flit countdown.
    // Outputs are cleared on the edge that accepts the last flit, so they already read zero in REL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_grant          <= '0;
            o_grant_priority <= '0;
            o_busy           <= 1'b0;
            o_random_robin   <= 1'b0;
            o_flit_cnt       <= '0;
            snapshot         <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (any_grant) begin
                        o_grant          <= grant_lsb;
                        o_grant_priority <= i_arb_priority;
                        snapshot         <= i_port_req;
                        o_flit_cnt       <= start_len;
                        o_busy           <= 1'b1;
                        o_random_robin   <= i_rr_enable;
                    end
                end
                S_LOCK: begin
                    o_random_robin <= 1'b0;
                end
                S_XFER: begin
                    if (last_flit) begin
                        o_grant          <= '0;
                        o_grant_priority <= '0;
                        o_flit_cnt       <= '0;
                        o_busy           <= 1'b0;
                    end else if (i_accept) begin
                        o_flit_cnt <= o_flit_cnt - ONE_FLIT;
                    end
                end
                S_REL: begin
                    o_grant          <= '0;
                    o_grant_priority <= '0;
                    o_flit_cnt       <= '0;
                    o_busy           <= 1'b0;
                    o_random_robin   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Structural invariants of the port
    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(o_grant));
    a_prio_onehot0:  assert property (@(posedge clk) disable iff (reset) $onehot0(o_grant_priority));
    a_done_in_xfer:  assert property (@(posedge clk) disable iff (reset) o_done |-> (state == S_XFER));

endmodule
